// File: rtl/output_port_credit_ctrl.sv
// Router output link register with per-VC downstream credit counters.
// Define OUTPORT_CREDIT_CHECK_EN to add the sticky credit_err_o protocol checker.
module output_port_credit_ctrl #(
    parameter type         flit_payload_t  = logic [256-1:0],
    parameter type         io_port_t       = logic [2:0],
    parameter int unsigned VC_NUM          = 1,
    parameter int unsigned VC_DEPTH        = 1,
    parameter int unsigned VC_NUM_IDX_W    = VC_NUM > 1 ? $clog2(VC_NUM) : 1,
    parameter int unsigned VC_ID_NUM_MAX_W = VC_NUM_IDX_W,
    parameter int unsigned CRD_CNT_W       = $clog2(VC_DEPTH + 1),
    parameter int unsigned OUTPUT_PORT_NO  = 0
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 st_flit_v_i,
    input  flit_payload_t                        st_flit_i,
    input  logic [VC_NUM_IDX_W-1:0]              st_flit_vc_id_i,
    input  io_port_t                             st_flit_look_ahead_routing_i,
    output logic                                 tx_flit_pend_o,
    output logic                                 tx_flit_v_o,
    output flit_payload_t                        tx_flit_o,
    output logic [VC_NUM_IDX_W-1:0]              tx_flit_vc_id_o,
    output io_port_t                             tx_flit_look_ahead_routing_o,
    input  logic                                 tx_lcrd_v_i,
    input  logic [VC_ID_NUM_MAX_W-1:0]           tx_lcrd_id_i,
    output logic [VC_NUM-1:0]                    vc_credit_avail_o,
    output logic [VC_NUM-1:0][CRD_CNT_W-1:0]     vc_credit_cnt_o,
`ifdef OUTPORT_CREDIT_CHECK_EN
    output logic                                 credit_err_o,
`endif
    output logic                                 vc_all_free_o
);

    localparam logic [CRD_CNT_W-1:0] FULL = CRD_CNT_W'(VC_DEPTH);
    localparam logic [CRD_CNT_W-1:0] ONE  = CRD_CNT_W'(1);

    logic [VC_NUM-1:0][CRD_CNT_W-1:0] cnt_q, cnt_d;
    logic [VC_NUM-1:0]                send, ret;

    logic                    tx_v_q;
    flit_payload_t           tx_flit_q;
    logic [VC_NUM_IDX_W-1:0] tx_vc_q;
    io_port_t                tx_route_q;

    // Send and return on the same VC cancel; otherwise the counter saturates.
    always_comb begin
        cnt_d = cnt_q;
        send  = '0;
        ret   = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            send[v] = st_flit_v_i && (int'(st_flit_vc_id_i) == v);
            ret[v]  = tx_lcrd_v_i && (int'(tx_lcrd_id_i) == v);
            case ({send[v], ret[v]})
                2'b10: if (cnt_q[v] != '0) cnt_d[v] = cnt_q[v] - ONE;
                2'b01: if (cnt_q[v] != FULL) cnt_d[v] = cnt_q[v] + ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= {VC_NUM{FULL}};
            tx_v_q     <= 1'b0;
            tx_flit_q  <= '0;
            tx_vc_q    <= '0;
            tx_route_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tx_v_q <= st_flit_v_i;
            if (st_flit_v_i) begin
                tx_flit_q  <= st_flit_i;
                tx_vc_q    <= st_flit_vc_id_i;
                tx_route_q <= st_flit_look_ahead_routing_i;
            end
        end
    end

    always_comb begin
        vc_all_free_o = 1'b1;
        for (int v = 0; v < VC_NUM; v++) begin
            vc_credit_avail_o[v] = (cnt_q[v] != '0);
            vc_all_free_o        = vc_all_free_o && (cnt_q[v] == FULL);
        end
    end

    assign vc_credit_cnt_o              = cnt_q;
    assign tx_flit_pend_o               = st_flit_v_i;
    assign tx_flit_v_o                  = tx_v_q;
    assign tx_flit_o                    = tx_flit_q;
    assign tx_flit_vc_id_o              = tx_vc_q;
    assign tx_flit_look_ahead_routing_o = tx_route_q;

`ifdef OUTPORT_CREDIT_CHECK_EN
    logic [VC_NUM-1:0] uflow, oflow;
    logic              rng_err;
    logic              err_q, err_d;

    always_comb begin
        uflow = '0;
        oflow = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            uflow[v] = send[v] && !ret[v] && (cnt_q[v] == '0);
            oflow[v] = ret[v] && !send[v] && (cnt_q[v] == FULL);
        end
        rng_err = tx_lcrd_v_i && (int'(tx_lcrd_id_i) >= int'(VC_NUM));
        err_d   = err_q || (|uflow) || (|oflow) || rng_err;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (uflow[v])
                    $display("[outport %0d] t=%0t vc=%0d credit underflow",
                             OUTPUT_PORT_NO, $time, v);
                if (oflow[v])
                    $display("[outport %0d] t=%0t vc=%0d credit overflow",
                             OUTPUT_PORT_NO, $time, v);
            end
            if (rng_err)
                $display("[outport %0d] t=%0t vc=%0d credit id out of range",
                         OUTPUT_PORT_NO, $time, tx_lcrd_id_i);
        end
    end
`endif

    assign credit_err_o = err_q;
`endif

endmodule

// File: tb/tb_output_port_credit_ctrl.sv
// Directed bench for output_port_credit_ctrl with a link-flit scoreboard.
// Error-flag checks are compiled in when OUTPORT_CREDIT_CHECK_EN is defined.
module tb_output_port_credit_ctrl;

    typedef logic [31:0] pl_t;
    typedef logic [2:0]  rt_t;
    typedef struct packed {
        pl_t  pl;
        logic vc;
        rt_t  rt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstn;
    logic             st_flit_v_i;
    pl_t              st_flit_i;
    logic             st_flit_vc_id_i;
    rt_t              st_flit_look_ahead_routing_i;
    logic             tx_flit_pend_o;
    logic             tx_flit_v_o;
    pl_t              tx_flit_o;
    logic             tx_flit_vc_id_o;
    rt_t              tx_flit_look_ahead_routing_o;
    logic             tx_lcrd_v_i;
    logic [1:0]       tx_lcrd_id_i;
    logic [1:0]       vc_credit_avail_o;
    logic [1:0][1:0]  vc_credit_cnt_o;
    logic             vc_all_free_o;
`ifdef OUTPORT_CREDIT_CHECK_EN
    logic             credit_err_o;
`endif

    int   n_run = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic exp_v = 1'b0;

    always #5 clk = ~clk;

    output_port_credit_ctrl #(
        .flit_payload_t (pl_t),
        .io_port_t      (rt_t),
        .VC_NUM         (2),
        .VC_DEPTH       (2),
        .VC_NUM_IDX_W   (1),
        .VC_ID_NUM_MAX_W(2),
        .CRD_CNT_W      (2),
        .OUTPUT_PORT_NO (3)
    ) dut (
        .clk                         (clk),
        .rstn                        (rstn),
        .st_flit_v_i                 (st_flit_v_i),
        .st_flit_i                   (st_flit_i),
        .st_flit_vc_id_i             (st_flit_vc_id_i),
        .st_flit_look_ahead_routing_i(st_flit_look_ahead_routing_i),
        .tx_flit_pend_o              (tx_flit_pend_o),
        .tx_flit_v_o                 (tx_flit_v_o),
        .tx_flit_o                   (tx_flit_o),
        .tx_flit_vc_id_o             (tx_flit_vc_id_o),
        .tx_flit_look_ahead_routing_o(tx_flit_look_ahead_routing_o),
        .tx_lcrd_v_i                 (tx_lcrd_v_i),
        .tx_lcrd_id_i                (tx_lcrd_id_i),
        .vc_credit_avail_o           (vc_credit_avail_o),
        .vc_credit_cnt_o             (vc_credit_cnt_o),
`ifdef OUTPORT_CREDIT_CHECK_EN
        .credit_err_o                (credit_err_o),
`endif
        .vc_all_free_o               (vc_all_free_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic vc, input pl_t pl,
                         input rt_t rt, input logic lv, input logic [1:0] lid);
        st_flit_v_i                  = sv;
        st_flit_vc_id_i              = vc;
        st_flit_i                    = pl;
        st_flit_look_ahead_routing_i = rt;
        tx_lcrd_v_i                  = lv;
        tx_lcrd_id_i                 = lid;
        exp_v                        = sv;
        if (sv) sb.push_back('{pl: pl, vc: vc, rt: rt});
        #1;
        chk("pend", 32'(tx_flit_pend_o), 32'(sv));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 2'd0);
    endtask

    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".v"}, 32'(tx_flit_v_o), 32'(exp_v));
        if (tx_flit_v_o) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, ".pl"}, tx_flit_o, e.pl);
                chk({tag, ".vc"}, 32'(tx_flit_vc_id_o), 32'(e.vc));
                chk({tag, ".rt"}, 32'(tx_flit_look_ahead_routing_o), 32'(e.rt));
            end
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] cnt,
                           input logic [1:0] avail, input logic free);
        chk({tag, ".cnt"}, 32'(vc_credit_cnt_o), 32'(cnt));
        chk({tag, ".avail"}, 32'(vc_credit_avail_o), 32'(avail));
        chk({tag, ".free"}, 32'(vc_all_free_o), 32'(free));
    endtask

    task automatic chk_err(input string tag, input logic e);
`ifdef OUTPORT_CREDIT_CHECK_EN
        chk({tag, ".err"}, 32'(credit_err_o), 32'(e));
`else
        if (e === 1'bx) chk({tag, ".err_arg"}, 32'(e), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        st_flit_v_i = 1'b0;
        st_flit_i = '0;
        st_flit_vc_id_i = 1'b0;
        st_flit_look_ahead_routing_i = '0;
        tx_lcrd_v_i = 1'b0;
        tx_lcrd_id_i = '0;
        #3;
        st_flit_v_i = 1'b1;
        #1;
        chk("rst.pend_hi", 32'(tx_flit_pend_o), 32'd1);
        chk("rst.v", 32'(tx_flit_v_o), 32'd0);
        st_flit_v_i = 1'b0;
        #1;
        chk("rst.pend_lo", 32'(tx_flit_pend_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk_cnt("reset", 4'b1010, 2'b11, 1'b1);
        chk("reset.v", 32'(tx_flit_v_o), 32'd0);
        chk("reset.pl", tx_flit_o, 32'd0);
        chk("reset.vc", 32'(tx_flit_vc_id_o), 32'd0);
        chk("reset.rt", 32'(tx_flit_look_ahead_routing_o), 32'd0);
        chk_err("reset", 1'b0);

        drive(1'b1, 1'b0, 32'hA0A0_0001, 3'd3, 1'b0, 2'd0);
        tick("send1");
        chk_cnt("send1", 4'b1001, 2'b11, 1'b0);
        drive(1'b1, 1'b0, 32'hB0B0_0002, 3'd5, 1'b0, 2'd0);
        tick("send2");
        chk_cnt("send2", 4'b1000, 2'b10, 1'b0);

        drive(1'b0, 1'b0, '0, '0, 1'b1, 2'd0);
        tick("ret0");
        chk_cnt("ret0", 4'b1001, 2'b11, 1'b0);
        chk("ret0.hold", tx_flit_o, 32'hB0B0_0002);

        drive(1'b1, 1'b0, 32'hC0C0_0003, 3'd1, 1'b1, 2'd0);
        tick("same_vc");
        chk_cnt("same_vc", 4'b1001, 2'b11, 1'b0);
        drive(1'b1, 1'b1, 32'hD0D0_0004, 3'd2, 1'b1, 2'd0);
        tick("diff_vc");
        chk_cnt("diff_vc", 4'b0110, 2'b11, 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 2'd1);
        tick("ret1");
        chk_cnt("ret1", 4'b1010, 2'b11, 1'b1);

        drive(1'b0, 1'b0, '0, '0, 1'b1, 2'd1);
        tick("oflow");
        chk_cnt("oflow", 4'b1010, 2'b11, 1'b1);
        chk_err("oflow", 1'b1);
        idle();
        tick("sticky");
        chk_err("sticky", 1'b1);

        drive(1'b1, 1'b0, 32'hE0E0_0005, 3'd0, 1'b0, 2'd0);
        tick("mid1");
        drive(1'b1, 1'b1, 32'hF0F0_0006, 3'd4, 1'b0, 2'd0);
        tick("mid2");
        chk_cnt("mid2", 4'b0101, 2'b11, 1'b0);
        idle();
        rstn = 1'b0;
        #1;
        chk("midrst.v", 32'(tx_flit_v_o), 32'd0);
        chk_cnt("midrst", 4'b1010, 2'b11, 1'b1);
        chk_err("midrst", 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        drive(1'b0, 1'b0, '0, '0, 1'b1, 2'd3);
        tick("range");
        chk_cnt("range", 4'b1010, 2'b11, 1'b1);
        chk_err("range", 1'b1);

        idle();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk_err("rst2", 1'b0);

        drive(1'b1, 1'b0, 32'h1111_0007, 3'd6, 1'b0, 2'd0);
        tick("uf1");
        drive(1'b1, 1'b0, 32'h2222_0008, 3'd7, 1'b0, 2'd0);
        tick("uf2");
        chk_cnt("uf2", 4'b1000, 2'b10, 1'b0);
        chk_err("uf2", 1'b0);
        drive(1'b1, 1'b0, 32'h3333_0009, 3'd1, 1'b0, 2'd0);
        tick("uflow");
        chk_cnt("uflow", 4'b1000, 2'b10, 1'b0);
        chk_err("uflow", 1'b1);
        idle();
        tick("drain");
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
